// File: rtl/rom_loader_pkg.sv
// Shared definitions for the ROM loader: FSM state encoding, frame field
// sizes and default parameter values.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  // Bytes in the little-endian length field and in one ROM word.
  localparam int LEN_BYTES  = 4;
  localparam int WORD_BYTES = 4;

  localparam int DEFAULT_DEPTH   = 4096;
  localparam int DEFAULT_TIMEOUT = 100000;

endpackage

// File: rtl/rom_loader_timer.sv
// Idle watchdog for the loader. Counts consecutive idle cycles and flags the
// cycle that would be the TIMEOUT_CYC-th idle one, so the owner can leave its
// loading state exactly TIMEOUT_CYC cycles after the last accepted byte.
module rom_loader_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  // Idle counter: clear wins over count; holds at the limit instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != LAST_IDLE)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expire_o = en_i && (r_cnt == LAST_IDLE);

endmodule

// File: rtl/rom_loader.sv
// Instruction ROM loader. Receives a framed image (4-byte LE word count,
// LE payload words, XOR checksum byte), writes each assembled word to the ROM
// at byte address word_index<<2 and holds the core in reset until the whole
// image has been received and its checksum verified.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        rom_we_o,
  output logic [31:0] rom_waddr_o,
  output logic [31:0] rom_wdata_o,
  output logic        core_rst_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_len;       // word count, shifted in LSB first
  logic [23:0] r_word;      // first three bytes of the word in flight
  logic [29:0] r_word_idx;  // index of the next word to write
  logic [1:0]  r_byte_cnt;  // byte position within length field or word
  logic [7:0]  r_csum;
  logic        r_we;
  logic [31:0] r_waddr;
  logic [31:0] r_wdata;

  logic        w_active;
  logic        w_accept;
  logic        w_byte_last;
  logic        w_start_load;
  logic        w_expire;
  logic        w_tmr_clr;
  logic        w_tmr_en;
  logic [31:0] w_len_full;
  logic [31:0] w_len_m1;
  logic [31:0] w_word_full;
  logic        w_word_last;

  assign w_active     = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);
  assign w_accept     = w_active && byte_valid_i;
  assign w_start_load = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_byte_last  = (r_state == ST_LEN) ? (r_byte_cnt == 2'(LEN_BYTES - 1))
                                            : (r_byte_cnt == 2'(WORD_BYTES - 1));
  // Value of each field as it will be once the current byte is shifted in.
  assign w_len_full   = {byte_i, r_len[31:8]};
  assign w_word_full  = {byte_i, r_word};
  assign w_len_m1     = r_len - 32'd1;
  assign w_word_last  = ({2'b00, r_word_idx} == w_len_m1);

  assign w_tmr_clr    = w_accept || !w_active;
  assign w_tmr_en     = w_active && !w_accept;

  rom_loader_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (w_tmr_clr),
    .en_i     (w_tmr_en),
    .expire_o (w_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: frame parsing, checksum verdict and idle timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_state_next = ST_LEN;
      end
      ST_LEN: begin
        if (w_expire) begin
          w_state_next = ST_ERR;
        end else if (w_accept && w_byte_last) begin
          if (w_len_full > 32'(DEPTH))   w_state_next = ST_ERR;
          else if (w_len_full == 32'd0)  w_state_next = ST_CSUM;
          else                           w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_expire) begin
          w_state_next = ST_ERR;
        end else if (w_accept && w_byte_last && w_word_last) begin
          w_state_next = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (w_expire) begin
          w_state_next = ST_ERR;
        end else if (w_accept) begin
          w_state_next = (byte_i == r_csum) ? ST_DONE : ST_ERR;
        end
      end
      ST_DONE, ST_ERR: begin
        if (start_i) w_state_next = ST_LEN;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: length/word assembly, checksum and the one-cycle write strobe.
  // Reset has priority, so a strobe scheduled on the reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len      <= '0;
      r_word     <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_csum     <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start_load) begin
        r_len      <= '0;
        r_word     <= '0;
        r_word_idx <= '0;
        r_byte_cnt <= '0;
        r_csum     <= '0;
      end else if (w_accept) begin
        case (r_state)
          ST_LEN: begin
            r_len      <= w_len_full;
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
          ST_DATA: begin
            r_word     <= w_word_full[31:8];
            r_csum     <= r_csum ^ byte_i;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_byte_last) begin
              r_we       <= 1'b1;
              r_waddr    <= {r_word_idx, 2'b00};
              r_wdata    <= w_word_full;
              r_word_idx <= r_word_idx + 30'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign byte_ready_o = w_active;
  assign rom_we_o     = r_we;
  assign rom_waddr_o  = r_waddr;
  assign rom_wdata_o  = r_wdata;
  assign core_rst_o   = (r_state != ST_DONE);
  assign load_done_o  = (r_state == ST_DONE);
  assign load_err_o   = (r_state == ST_ERR);

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: scenario tasks drive frames, expected
// ROM writes go into a scoreboard queue and are popped by a strobe monitor.
module tb_rom_loader;

  localparam int DEPTH       = 4096;
  localparam int TIMEOUT_CYC = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_ready_o;
  logic        rom_we_o;
  logic [31:0] rom_waddr_o;
  logic [31:0] rom_wdata_o;
  logic        core_rst_o;
  logic        load_done_o;
  logic        load_err_o;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          strobes = 0;
  int          cyc = 0;
  int          strobe_cyc[$];
  logic [63:0] sb_q[$];
  logic [63:0] sb_exp;
  logic [7:0]  csum;

  rom_loader #(
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .rom_we_o     (rom_we_o),
    .rom_waddr_o  (rom_waddr_o),
    .rom_wdata_o  (rom_wdata_o),
    .core_rst_o   (core_rst_o),
    .load_done_o  (load_done_o),
    .load_err_o   (load_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rom_we_o === 1'b1) begin
      strobes++;
      strobe_cyc.push_back(cyc);
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_mis++;
        $display("FAIL strobe_unexpected got addr=%h data=%h want no strobe", rom_waddr_o, rom_wdata_o);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({rom_waddr_o, rom_wdata_o} !== sb_exp) begin
          n_mis++;
          $display("FAIL strobe_write got addr=%h data=%h want addr=%h data=%h",
                   rom_waddr_o, rom_wdata_o, sb_exp[63:32], sb_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    csum = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waitc;
    waitc = 0;
    byte_i = b;
    byte_valid_i = 1'b1;
    @(negedge clk);
    while (byte_ready_o !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (byte_ready_o !== 1'b1) begin
      n_cmp++; n_mis++;
      $display("FAIL byte_accept got ready=%b want 1 within 50 cycles", byte_ready_o);
    end
    @(posedge clk); #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
  endtask

  // Sends one payload word LSB first and records the write it should cause.
  task automatic send_word(input int idx, input logic [31:0] w);
    logic [31:0] a;
    a = 32'(idx) << 2;
    sb_q.push_back({a, w});
    for (int i = 0; i < 4; i++) begin
      csum = csum ^ w[8*i +: 8];
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00;
    settle(3);
    rst = 1'b0;
    settle(1);
    n_cmp++; if (byte_ready_o !== 1'b0) begin n_mis++; $display("FAIL reset_ready got %b want 0", byte_ready_o); end
    n_cmp++; if (rom_we_o !== 1'b0) begin n_mis++; $display("FAIL reset_we got %b want 0", rom_we_o); end
    n_cmp++; if (rom_waddr_o !== 32'h0) begin n_mis++; $display("FAIL reset_waddr got %h want 0", rom_waddr_o); end
    n_cmp++; if (rom_wdata_o !== 32'h0) begin n_mis++; $display("FAIL reset_wdata got %h want 0", rom_wdata_o); end
    n_cmp++; if (core_rst_o !== 1'b1) begin n_mis++; $display("FAIL reset_core_rst got %b want 1", core_rst_o); end
    n_cmp++; if (load_done_o !== 1'b0) begin n_mis++; $display("FAIL reset_done got %b want 0", load_done_o); end
    n_cmp++; if (load_err_o !== 1'b0) begin n_mis++; $display("FAIL reset_err got %b want 0", load_err_o); end
  endtask

  task automatic test_happy();
    int s0;
    s0 = strobes;
    pulse_start();
    send_len(32'd2);
    send_word(0, 32'h00A00093);
    // A start pulse mid-load must not restart the frame.
    pulse_start();
    csum = 8'h93 ^ 8'hA0;
    send_word(1, 32'h00108113);
    n_cmp++; if (core_rst_o !== 1'b1) begin n_mis++; $display("FAIL happy_core_rst_pre got %b want 1", core_rst_o); end
    send_byte(csum);
    n_cmp++; if (load_done_o !== 1'b1) begin n_mis++; $display("FAIL happy_done got %b want 1", load_done_o); end
    n_cmp++; if (core_rst_o !== 1'b0) begin n_mis++; $display("FAIL happy_core_rst got %b want 0", core_rst_o); end
    n_cmp++; if (load_err_o !== 1'b0) begin n_mis++; $display("FAIL happy_err got %b want 0", load_err_o); end
    // Offered bytes while not ready are ignored.
    byte_i = 8'hFF; byte_valid_i = 1'b1;
    settle(3);
    byte_valid_i = 1'b0;
    n_cmp++; if ({load_done_o, byte_ready_o} !== 2'b10) begin n_mis++; $display("FAIL happy_hold got done,ready=%b want 10", {load_done_o, byte_ready_o}); end
    n_cmp++; if (strobes - s0 !== 2) begin n_mis++; $display("FAIL happy_strobes got %0d want 2", strobes - s0); end
    n_cmp++; if (sb_q.size() !== 0) begin n_mis++; $display("FAIL happy_sb_left got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_bad_csum();
    int s0;
    s0 = strobes;
    pulse_start();
    n_cmp++; if ({core_rst_o, load_done_o} !== 2'b10) begin n_mis++; $display("FAIL bad_restart got core_rst,done=%b want 10", {core_rst_o, load_done_o}); end
    send_len(32'd2);
    send_word(0, 32'h00A00093);
    send_word(1, 32'h00108113);
    send_byte(csum ^ 8'h01);
    settle(2);
    n_cmp++; if (load_err_o !== 1'b1) begin n_mis++; $display("FAIL bad_err got %b want 1", load_err_o); end
    n_cmp++; if ({core_rst_o, load_done_o} !== 2'b10) begin n_mis++; $display("FAIL bad_core got core_rst,done=%b want 10", {core_rst_o, load_done_o}); end
    n_cmp++; if (strobes - s0 !== 2) begin n_mis++; $display("FAIL bad_strobes got %0d want 2", strobes - s0); end
  endtask

  task automatic test_oversize();
    int s0;
    s0 = strobes;
    pulse_start();
    n_cmp++; if (load_err_o !== 1'b0) begin n_mis++; $display("FAIL over_err_clear got %b want 0", load_err_o); end
    send_len(32'(DEPTH + 1));
    n_cmp++; if ({load_err_o, byte_ready_o} !== 2'b10) begin n_mis++; $display("FAIL over_err got err,ready=%b want 10", {load_err_o, byte_ready_o}); end
    settle(2);
    n_cmp++; if (strobes - s0 !== 0) begin n_mis++; $display("FAIL over_strobes got %0d want 0", strobes - s0); end
  endtask

  task automatic test_zero_len();
    int s0;
    s0 = strobes;
    pulse_start();
    send_len(32'd0);
    send_byte(8'h00);
    n_cmp++; if (load_done_o !== 1'b1) begin n_mis++; $display("FAIL zero_done got %b want 1", load_done_o); end
    pulse_start();
    send_len(32'd0);
    send_byte(8'h01);
    n_cmp++; if (load_err_o !== 1'b1) begin n_mis++; $display("FAIL zero_err got %b want 1", load_err_o); end
    n_cmp++; if (strobes - s0 !== 0) begin n_mis++; $display("FAIL zero_strobes got %0d want 0", strobes - s0); end
  endtask

  // Start and a valid byte in the same cycle: the byte must not be consumed.
  task automatic test_start_with_valid();
    start_i = 1'b1; byte_valid_i = 1'b1; byte_i = 8'hAA;
    @(posedge clk); #1;
    start_i = 1'b0; byte_valid_i = 1'b0;
    csum = 8'h00;
    send_len(32'd1);
    send_word(0, 32'hDEADBEEF);
    send_byte(csum);
    settle(1);
    n_cmp++; if (load_done_o !== 1'b1) begin n_mis++; $display("FAIL startvalid_done got %b want 1", load_done_o); end
    n_cmp++; if (sb_q.size() !== 0) begin n_mis++; $display("FAIL startvalid_sb_left got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_timeout();
    int k;
    int s0;
    s0 = strobes;
    pulse_start();
    send_len(32'd1);
    send_byte(8'h11);
    k = 0;
    while (k < 40 && load_err_o !== 1'b1) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++; if (k !== TIMEOUT_CYC) begin n_mis++; $display("FAIL timeout_cycles got %0d want %0d", k, TIMEOUT_CYC); end
    n_cmp++; if (strobes - s0 !== 0) begin n_mis++; $display("FAIL timeout_strobes got %0d want 0", strobes - s0); end
  endtask

  task automatic test_back_to_back();
    int s0;
    int base;
    s0 = strobes;
    base = strobe_cyc.size();
    pulse_start();
    send_len(32'd4);
    for (int i = 0; i < 4; i++) send_word(i, $urandom);
    send_byte(csum);
    settle(1);
    n_cmp++; if (load_done_o !== 1'b1) begin n_mis++; $display("FAIL b2b_done got %b want 1", load_done_o); end
    n_cmp++; if (strobes - s0 !== 4) begin n_mis++; $display("FAIL b2b_strobes got %0d want 4", strobes - s0); end
    if (strobe_cyc.size() - base == 4) begin
      for (int i = 1; i < 4; i++) begin
        n_cmp++;
        if (strobe_cyc[base + i] - strobe_cyc[base + i - 1] !== 4) begin
          n_mis++;
          $display("FAIL b2b_spacing got %0d want 4 cycles", strobe_cyc[base + i] - strobe_cyc[base + i - 1]);
        end
      end
    end
  endtask

  // Reset during the payload; the second word's last byte lands on the reset edge.
  task automatic test_reset_mid();
    int s0;
    s0 = strobes;
    pulse_start();
    send_len(32'd3);
    send_word(0, 32'h11223344);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    byte_i = 8'h88; byte_valid_i = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    byte_valid_i = 1'b0;
    settle(1);
    rst = 1'b0;
    settle(1);
    n_cmp++;
    if ({byte_ready_o, rom_we_o, rom_waddr_o, rom_wdata_o, core_rst_o, load_done_o, load_err_o} !==
        {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      n_mis++;
      $display("FAIL midrst_outputs got ready=%b we=%b addr=%h data=%h crst=%b done=%b err=%b want 0 0 0 0 1 0 0",
               byte_ready_o, rom_we_o, rom_waddr_o, rom_wdata_o, core_rst_o, load_done_o, load_err_o);
    end
    settle(5);
    n_cmp++; if (strobes - s0 !== 1) begin n_mis++; $display("FAIL midrst_strobes got %0d want 1", strobes - s0); end
  endtask

  task automatic test_recover();
    pulse_start();
    send_len(32'd2);
    send_word(0, 32'h00A00093);
    send_word(1, 32'h00108113);
    send_byte(csum);
    settle(1);
    n_cmp++; if ({load_done_o, core_rst_o} !== 2'b10) begin n_mis++; $display("FAIL recover_done got done,crst=%b want 10", {load_done_o, core_rst_o}); end
    n_cmp++; if (sb_q.size() !== 0) begin n_mis++; $display("FAIL recover_sb_left got %0d want 0", sb_q.size()); end
  endtask

  task automatic test_full_depth();
    int s0;
    s0 = strobes;
    pulse_start();
    send_len(32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) send_word(i, $urandom);
    send_byte(csum);
    settle(2);
    n_cmp++; if (load_done_o !== 1'b1) begin n_mis++; $display("FAIL full_done got %b want 1", load_done_o); end
    n_cmp++; if (strobes - s0 !== DEPTH) begin n_mis++; $display("FAIL full_strobes got %0d want %0d", strobes - s0, DEPTH); end
    n_cmp++; if (rom_waddr_o !== 32'((DEPTH - 1) * 4)) begin n_mis++; $display("FAIL full_last_addr got %h want %h", rom_waddr_o, 32'((DEPTH - 1) * 4)); end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_i = 8'h00; csum = 8'h00;
    test_reset();
    test_happy();
    test_bad_csum();
    test_oversize();
    test_zero_len();
    test_start_with_valid();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_recover();
    test_full_depth();
    settle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
